// File: rtl/mem_access_ctrl.sv
// Memory access controller: byte/half/word loads and stores against a
// 32-bit synchronous RAM with a 2-cycle read latency (output register).
// Sub-word stores are done as read-modify-write. Misaligned requests are
// rejected without touching the RAM.
module mem_access_ctrl #(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clka,
    input  logic                  rsta_n,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    input  logic [31:0]           i_addr,
    input  logic [31:0]           i_wdata,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_misalign,
    output logic [31:0]           o_rdata,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [31:0]           o_ram_din,
    output logic                  o_ram_we,
    output logic                  o_ram_en,
    output logic                  o_ram_regce,
    output logic                  o_ram_rst,
    input  logic [31:0]           i_ram_dout
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        RD_CAPTURE,
        WRITE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    // Request capture registers
    logic                    r_we;
    logic [1:0]              r_size;
    logic                    r_unsigned;
    logic [ADDR_WIDTH-1:0]   r_word_addr;
    logic [1:0]              r_lane;
    logic [31:0]             r_wdata;

    // Data path / status registers
    logic [31:0]             r_rd_word;
    logic [31:0]             r_rdata;
    logic                    r_done;
    logic                    r_misalign;

    logic                    w_accept;
    logic                    w_misalign_in;
    logic                    w_ram_en;
    logic                    w_ram_we;
    logic                    w_ram_regce;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [31:0]             w_load_value;
    logic [3:0]              w_lane_hit;
    logic [31:0]             w_merge_word;
    logic                    w_unused_addr_bits;

    // Address bits above the RAM word range wrap silently.
    assign w_unused_addr_bits = ^i_addr[31:ADDR_WIDTH+2];

    assign w_accept = (r_state == IDLE) && i_req;

    // Alignment check on the incoming request (size 11 is always illegal)
    always_comb begin
        w_misalign_in = 1'b1;
        case (i_size)
            SZ_BYTE: w_misalign_in = 1'b0;
            SZ_HALF: w_misalign_in = i_addr[0];
            SZ_WORD: w_misalign_in = |i_addr[1:0];
            default: w_misalign_in = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and Moore RAM controls
    always_comb begin
        w_state_next = r_state;
        w_ram_en     = 1'b0;
        w_ram_we     = 1'b0;
        w_ram_regce  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_req && !w_misalign_in) begin
                    // Full-word stores need no read; everything else reads first.
                    if (i_we && (i_size == SZ_WORD)) begin
                        w_state_next = WRITE;
                    end else begin
                        w_state_next = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                w_ram_en     = 1'b1;
                w_state_next = RD_WAIT;
            end
            RD_WAIT: begin
                w_ram_regce  = 1'b1;
                w_state_next = RD_CAPTURE;
            end
            RD_CAPTURE: begin
                w_state_next = r_we ? WRITE : IDLE;
            end
            WRITE: begin
                w_ram_en     = 1'b1;
                w_ram_we     = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Capture the request fields at the accept edge
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_word_addr <= '0;
            r_lane      <= 2'b00;
            r_wdata     <= 32'h0;
        end else if (w_accept) begin
            r_we        <= i_we;
            r_size      <= i_size;
            r_unsigned  <= i_unsigned;
            r_word_addr <= i_addr[ADDR_WIDTH+1:2];
            r_lane      <= i_addr[1:0];
            r_wdata     <= i_wdata;
        end
    end

    // Lane selection and extension for loads (little-endian lanes)
    always_comb begin
        w_byte = 8'h00;
        case (r_lane)
            2'd0:    w_byte = i_ram_dout[7:0];
            2'd1:    w_byte = i_ram_dout[15:8];
            2'd2:    w_byte = i_ram_dout[23:16];
            default: w_byte = i_ram_dout[31:24];
        endcase
        w_half = r_lane[1] ? i_ram_dout[31:16] : i_ram_dout[15:0];
        case (r_size)
            SZ_BYTE: w_load_value = {{24{~r_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: w_load_value = {{16{~r_unsigned & w_half[15]}}, w_half};
            default: w_load_value = i_ram_dout;
        endcase
    end

    // Store merge: replace only the addressed byte lanes of the read word
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign w_lane_hit[gi] = ((r_size == SZ_BYTE) && (r_lane == LANE)) ||
                                    ((r_size == SZ_HALF) && (r_lane[1] == LANE[1]));
            assign w_merge_word[8*gi +: 8] =
                !w_lane_hit[gi]                    ? r_rd_word[8*gi +: 8] :
                ((r_size == SZ_HALF) && LANE[0])   ? r_wdata[15:8]        :
                                                     r_wdata[7:0];
        end
    endgenerate

    // Register RAM data when leaving RD_CAPTURE; loads update o_rdata there too
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            r_rd_word <= 32'h0;
            r_rdata   <= 32'h0;
        end else if (r_state == RD_CAPTURE) begin
            r_rd_word <= i_ram_dout;
            if (!r_we) begin
                r_rdata <= w_load_value;
            end
        end
    end

    // One-cycle completion and misalignment pulses
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            r_done     <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_done     <= (w_accept && w_misalign_in) ||
                          ((r_state == RD_CAPTURE) && !r_we) ||
                          (r_state == WRITE);
            r_misalign <= w_accept && w_misalign_in;
        end
    end

    assign o_busy      = (r_state != IDLE);
    assign o_done      = r_done;
    assign o_misalign  = r_misalign;
    assign o_rdata     = r_rdata;
    assign o_ram_addr  = r_word_addr;
    assign o_ram_din   = (r_size == SZ_WORD) ? r_wdata : w_merge_word;
    assign o_ram_we    = w_ram_we;
    assign o_ram_en    = w_ram_en;
    assign o_ram_regce = w_ram_regce;
    assign o_ram_rst   = ~rsta_n;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural 2-cycle RAM and an
// expectation queue popped on each o_done pulse.
module tb_mem_access_ctrl;

    localparam int AW = 11;
    localparam logic [1:0] SB = 2'b00;
    localparam logic [1:0] SH = 2'b01;
    localparam logic [1:0] SW = 2'b10;
    localparam logic [1:0] SX = 2'b11;

    logic          clka = 1'b0;
    logic          rsta_n;
    logic          i_req;
    logic          i_we;
    logic [1:0]    i_size;
    logic          i_unsigned;
    logic [31:0]   i_addr;
    logic [31:0]   i_wdata;
    logic          o_busy;
    logic          o_done;
    logic          o_misalign;
    logic [31:0]   o_rdata;
    logic [AW-1:0] o_ram_addr;
    logic [31:0]   o_ram_din;
    logic          o_ram_we;
    logic          o_ram_en;
    logic          o_ram_regce;
    logic          o_ram_rst;
    logic [31:0]   ram_dout;

    logic [31:0]   ram_mem [0:(1<<AW)-1];
    logic [31:0]   ram_stage;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        bit          misalign;
        logic [31:0] rdata;
        int          lat;
        int          busy;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] exp_rdata_hold;

    mem_access_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clka        (clka),
        .rsta_n      (rsta_n),
        .i_req       (i_req),
        .i_we        (i_we),
        .i_size      (i_size),
        .i_unsigned  (i_unsigned),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_misalign  (o_misalign),
        .o_rdata     (o_rdata),
        .o_ram_addr  (o_ram_addr),
        .o_ram_din   (o_ram_din),
        .o_ram_we    (o_ram_we),
        .o_ram_en    (o_ram_en),
        .o_ram_regce (o_ram_regce),
        .o_ram_rst   (o_ram_rst),
        .i_ram_dout  (ram_dout)
    );

    initial forever #5 clka = ~clka;

    // RAM with one internal read stage plus an output register
    always @(posedge clka) begin
        if (o_ram_en) begin
            if (o_ram_we) ram_mem[o_ram_addr] <= o_ram_din;
            else          ram_stage <= ram_mem[o_ram_addr];
        end
        if (o_ram_rst)        ram_dout <= 32'h0;
        else if (o_ram_regce) ram_dout <= ram_stage;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one request in the current IDLE cycle; accepted at the next edge.
    task automatic start_op(input string tag, input logic we, input logic [1:0] size,
                            input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                            input bit mis, input bit is_load, input logic [31:0] load_val,
                            input int lat, input int busy);
        exp_t e;
        if (is_load && !mis) exp_rdata_hold = load_val;
        e.tag = tag; e.misalign = mis; e.rdata = exp_rdata_hold;
        e.lat = lat; e.busy = busy;
        sb_q.push_back(e);
        i_req = 1'b1; i_we = we; i_size = size; i_unsigned = uns;
        i_addr = addr; i_wdata = wdata;
        @(posedge clka);
        #1;
        // Garbage on the inputs while busy must be ignored.
        i_req = 1'b0; i_we = 1'($urandom); i_size = 2'($urandom);
        i_unsigned = 1'($urandom); i_addr = $urandom; i_wdata = $urandom;
    endtask

    task automatic ld(input string tag, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] val);
        start_op(tag, 1'b0, size, uns, addr, 32'h0, 1'b0, 1'b1, val, 4, 3);
    endtask

    task automatic st(input string tag, input logic [1:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata);
        if (size == SW) start_op(tag, 1'b1, size, 1'b0, addr, wdata, 1'b0, 1'b0, 32'h0, 2, 1);
        else            start_op(tag, 1'b1, size, 1'b0, addr, wdata, 1'b0, 1'b0, 32'h0, 5, 4);
    endtask

    task automatic bad(input string tag, input logic we, input logic [1:0] size,
                       input logic [31:0] addr);
        start_op(tag, we, size, 1'b0, addr, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0, 1, 0);
    endtask

    // Wait (bounded) for o_done, then pop and compare the oldest expectation.
    task automatic wait_done();
        exp_t e;
        int   k = 1;
        int   busy_n = 0;
        bit   seen_en = 1'b0;
        bit   got = 1'b0;
        repeat (20) begin
            @(negedge clka);
            if (o_ram_en) seen_en = 1'b1;
            if (o_done) begin
                got = 1'b1;
                break;
            end
            if (o_busy) busy_n++;
            @(posedge clka);
            k++;
        end
        assert (sb_q.size() > 0) else begin
            n_err++;
            $error("FAIL sb_underflow observed=0 entries expected>0");
            return;
        end
        e = sb_q.pop_front();
        check({e.tag, " done_seen"}, 32'(got), 32'd1);
        if (got) begin
            check({e.tag, " latency"}, 32'(k), 32'(e.lat));
            check({e.tag, " busy_cycles"}, 32'(busy_n), 32'(e.busy));
            check({e.tag, " busy_at_done"}, 32'(o_busy), 32'd0);
            check({e.tag, " misalign"}, 32'(o_misalign), 32'(e.misalign));
            check({e.tag, " rdata"}, o_rdata, e.rdata);
            if (e.misalign) check({e.tag, " no_ram_en"}, 32'(seen_en), 32'd0);
        end
        $display("[%0t] %s: done=%0b lat=%0d busy=%0d misalign=%0b rdata=%h",
                 $time, e.tag, got, k, busy_n, o_misalign, o_rdata);
    endtask

    // The cycle after a done pulse must have o_done low.
    task automatic idle_check(input string tag);
        @(negedge clka);
        check({tag, " done_one_cycle"}, 32'(o_done), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " busy"},     32'(o_busy),      32'd0);
        check({tag, " done"},     32'(o_done),      32'd0);
        check({tag, " misalign"}, 32'(o_misalign),  32'd0);
        check({tag, " ram_en"},   32'(o_ram_en),    32'd0);
        check({tag, " ram_we"},   32'(o_ram_we),    32'd0);
        check({tag, " regce"},    32'(o_ram_regce), 32'd0);
        check({tag, " rdata"},    o_rdata,          32'h0);
        check({tag, " ram_addr"}, 32'(o_ram_addr),  32'h0);
        check({tag, " ram_din"},  o_ram_din,        32'h0);
        check({tag, " ram_rst"},  32'(o_ram_rst),   32'd1);
    endtask

    initial begin
        bit saw_we;
        exp_t dropped;
        i_req = 1'b0; i_we = 1'b0; i_size = 2'b00; i_unsigned = 1'b0;
        i_addr = 32'h0; i_wdata = 32'h0;
        exp_rdata_hold = 32'h0;
        rsta_n = 1'b1;
        #2 rsta_n = 1'b0;
        repeat (3) @(negedge clka);
        check_reset_outputs("por");
        rsta_n = 1'b1;
        #1;
        check("por ram_rst_released", 32'(o_ram_rst), 32'd0);

        // Word store then load
        st("sw_10", SW, 32'h10, 32'hDEADBEEF);         wait_done(); idle_check("sw_10");
        check("mem_10", ram_mem[4], 32'hDEADBEEF);
        ld("lw_10", SW, 1'b0, 32'h10, 32'hDEADBEEF);  wait_done(); idle_check("lw_10");

        // Signed / unsigned sub-word loads
        st("sw_20", SW, 32'h20, 32'h80FF7F01);          wait_done(); idle_check("sw_20");
        ld("lb_23",  SB, 1'b0, 32'h23, 32'hFFFFFF80);  wait_done(); idle_check("lb_23");
        ld("lbu_23", SB, 1'b1, 32'h23, 32'h00000080);  wait_done(); idle_check("lbu_23");
        ld("lb_21",  SB, 1'b0, 32'h21, 32'h0000007F);  wait_done(); idle_check("lb_21");
        ld("lh_22",  SH, 1'b0, 32'h22, 32'hFFFF80FF);  wait_done(); idle_check("lh_22");
        ld("lhu_20", SH, 1'b1, 32'h20, 32'h00007F01);  wait_done(); idle_check("lhu_20");

        // Read-modify-write stores; o_busy spans the four non-IDLE states
        st("sw_30", SW, 32'h30, 32'h11223344);          wait_done(); idle_check("sw_30");
        st("sh_32", SH, 32'h32, 32'hAAAA5566);          wait_done(); idle_check("sh_32");
        check("mem_30_after_sh", ram_mem[12], 32'h55663344);
        st("sb_30", SB, 32'h30, 32'h00000099);          wait_done(); idle_check("sb_30");
        check("mem_30_after_sb", ram_mem[12], 32'h55663399);
        ld("lw_30", SW, 1'b0, 32'h30, 32'h55663399);   wait_done(); idle_check("lw_30");

        // Misaligned requests: pulse next cycle, no RAM access, rdata held
        bad("mis_lw_41", 1'b0, SW, 32'h41);  wait_done(); idle_check("mis_lw_41");
        bad("mis_lh_43", 1'b0, SH, 32'h43);  wait_done(); idle_check("mis_lh_43");
        bad("mis_sz11",  1'b0, SX, 32'h40);  wait_done(); idle_check("mis_sz11");
        bad("mis_sw_42", 1'b1, SW, 32'h42);  wait_done(); idle_check("mis_sw_42");

        // Reset asserted mid-cycle during the WRITE state of a byte store
        st("sw_50", SW, 32'h50, 32'hCAFEF00D);          wait_done(); idle_check("sw_50");
        st("sb_51_abort", SB, 32'h51, 32'h00000011);
        saw_we = 1'b0;
        repeat (10) begin
            @(negedge clka);
            if (o_ram_we) begin
                saw_we = 1'b1;
                break;
            end
        end
        check("rst_write_reached", 32'(saw_we), 32'd1);
        rsta_n = 1'b0;
        #1;
        check_reset_outputs("rst_in_write");
        dropped = sb_q.pop_front();
        $display("[%0t] %s: aborted by reset", $time, dropped.tag);
        exp_rdata_hold = 32'h0;
        repeat (3) begin
            @(negedge clka);
            check("rst_no_done", 32'(o_done), 32'd0);
        end
        check("mem_50_unchanged", ram_mem[20], 32'hCAFEF00D);
        rsta_n = 1'b1;
        #1;
        check("rst_released ram_rst", 32'(o_ram_rst), 32'd0);
        ld("lw_50_after_rst", SW, 1'b0, 32'h50, 32'hCAFEF00D); wait_done(); idle_check("lw_50");

        // Back-to-back (second request held in the done cycle) and address wrap
        st("sw_2000_wrap", SW, 32'h2000, 32'h12345678);  wait_done();
        ld("lw_0_b2b", SW, 1'b0, 32'h0, 32'h12345678);   wait_done(); idle_check("lw_0_b2b");
        check("mem_0_wrap", ram_mem[0], 32'h12345678);
        ld("lhu_2002_wrap", SH, 1'b1, 32'h2002, 32'h00001234); wait_done();
        ld("lb_3_b2b", SB, 1'b0, 32'h3, 32'h00000012);         wait_done(); idle_check("lb_3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
